pingpong_xpose_ram: RTL and testbench

- Double-buffered (ping-pong) block memory for 2-D 8x8 pipelines, e.g. the transpose stage between row and column DCT passes.
- The write side fills one bank in row-major order while the read side drains the other bank in column-major order.
- Both sides use valid/ready handshakes, so producer and consumer run concurrently at one sample per clock.

---
 rtl/pingpong_xpose_ram_pkg.sv | 19 +
 rtl/pingpong_xpose_ram_if.sv | 25 ++
 rtl/pingpong_xpose_ram_sdp_ram.sv | 31 +++
 rtl/pingpong_xpose_ram.sv | 134 +++++++++++++
 tb/tb_pingpong_xpose_ram.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pingpong_xpose_ram_pkg.sv
// Shared types and defaults for the ping-pong transpose buffer.
// The index mapping helper is used only when the XPOSE_EN build option is defined.
package pingpong_pkg;

  // Per-bank status: FREE banks may be written, FULL banks may be read.
  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

  localparam int BLK_N_DEF = 8;
  localparam int WIDTH_DEF = 8;

  // Column-major index for a row-major written n x n block.
  function automatic int unsigned xpose_map(input int unsigned r, input int unsigned n);
    return (r % n) * n + (r / n);
  endfunction

endpackage

// File: rtl/pingpong_xpose_ram_if.sv
// Producer/consumer handshake bundle for pingpong_xpose_ram.
// slave = the buffer itself; master = the environment driving it.
interface pingpong_xpose_ram_if
  import pingpong_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/pingpong_xpose_ram_sdp_ram.sv
// Simple dual-port storage for both banks; bank index is the address MSB.
// Read data is registered and holds whenever rd_en is low, which lets the
// output stage stall without re-reading.
module sdp_ram
  import pingpong_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = $clog2(2 * BLK_N_DEF * BLK_N_DEF)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [2**AW];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, held when not enabled.
  always_ff @(posedge clk) begin
    if (rd_en) dout <= mem[rd_addr];
  end

endmodule

// File: rtl/pingpong_xpose_ram.sv
// Double-buffered 8x8 block memory: one bank fills row-major while the other
// drains. Build option XPOSE_EN selects column-major draining (transpose);
// without it blocks come out in the order they went in.
module pingpong_xpose_ram
  import pingpong_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BLK_N = BLK_N_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  pingpong_xpose_ram_if.slave bus
);

  localparam int DEPTH = BLK_N * BLK_N;
  localparam int CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic             wr_bank;
  logic [CNT_W-1:0] wr_cnt;
  logic             rd_bank;
  logic [CNT_W-1:0] rd_cnt;
  bank_state_e      bank_st  [2];
  bank_state_e      bank_nxt [2];
  logic             out_valid_q;
  logic             out_last_q;

  logic             wr_fire;
  logic             wr_done;
  logic             issue;
  logic             rd_done;
  logic             stall;
  logic [CNT_W-1:0] rd_map;
  logic [WIDTH-1:0] ram_dout;

  // Handshake qualifiers, all derived from registered state.
  always_comb begin
    bus.in_ready = (bank_st[wr_bank] == BANK_FREE);
    wr_fire      = bus.in_valid && bus.in_ready;
    wr_done      = wr_fire && (wr_cnt == CNT_LAST);
    stall        = out_valid_q && !bus.out_ready;
    issue        = (bank_st[rd_bank] == BANK_FULL) && !stall;
    rd_done      = issue && (rd_cnt == CNT_LAST);
  end

  // Read-side address ordering within a bank.
  always_comb begin
`ifdef XPOSE_EN
    rd_map = CNT_W'(xpose_map(32'(rd_cnt), BLK_N));
`else
    rd_map = rd_cnt;
`endif
  end

  // Bank status next-state: a bank fills only while FREE and drains only
  // while FULL, so set and clear never collide on the same bank.
  always_comb begin
    bank_nxt = bank_st;
    if (wr_done) bank_nxt[wr_bank] = BANK_FULL;
    if (rd_done) bank_nxt[rd_bank] = BANK_FREE;
  end

  // Bank status register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_st <= '{default: BANK_FREE};
    end else begin
      bank_st <= bank_nxt;
    end
  end

  // Write pointer: advance per accepted sample, swap banks at block end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (wr_fire) begin
      if (wr_done) begin
        wr_bank <= !wr_bank;
        wr_cnt  <= '0;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Read pointer: advance per issued read, swap banks at block end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else if (issue) begin
      if (rd_done) begin
        rd_bank <= !rd_bank;
        rd_cnt  <= '0;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Output flags track the one-cycle memory read; both hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= issue || stall;
      if (issue) begin
        out_last_q <= rd_done;
      end else if (!stall) begin
        out_last_q <= 1'b0;
      end
    end
  end

  sdp_ram #(
    .WIDTH (WIDTH),
    .AW    (CNT_W + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank, wr_cnt}),
    .wr_data (bus.in_data),
    .rd_en   (issue),
    .rd_addr ({rd_bank, rd_map}),
    .dout    (ram_dout)
  );

  assign bus.out_data  = ram_dout;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_pingpong_xpose_ram.sv
// Bench for pingpong_xpose_ram: scoreboard of expected output samples filled
// as blocks complete on the input side, plus scenario table and corner cases.
module tb_pingpong_xpose_ram;

  localparam int W = 8;
  localparam int N = 8;
  localparam int D = N * N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pingpong_xpose_ram_if #(.WIDTH(W)) bus();

  pingpong_xpose_ram #(.WIDTH(W), .BLK_N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    int nblk;
    int vpct;
    int rpct;
    int exp_outs;
  } scen_t;

  exp_t         sb [$];
  logic [W-1:0] blk [D];
  int           wcnt;
  int           cyc;
  int           n_checks;
  int           n_pass;
  int           n_outs;
  int           blk_done_cyc;
  logic         prev_v, prev_r, prev_l;
  logic [W-1:0] prev_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int map_idx(input int k);
`ifdef XPOSE_EN
    return (k % N) * N + k / N;
`else
    return k;
`endif
  endfunction

  // One clock: drive at negedge, sample 1ns later, update model and scoreboard.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy,
                       output logic acc, output logic got, output logic gl);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    cyc++;
    if (prev_v && !prev_r) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'(prev_d));
      chk("stall_last", 32'(bus.out_last), 32'(prev_l));
    end
    if (!bus.out_valid) chk("idle_last", 32'(bus.out_last), 32'd0);
    acc = bus.in_valid && bus.in_ready;
    got = bus.out_valid && bus.out_ready;
    gl  = bus.out_last;
    if (acc) begin
      blk[wcnt] = d;
      wcnt++;
      if (wcnt == D) begin
        for (int k = 0; k < D; k++) begin
          e.data = blk[map_idx(k)];
          e.last = (k == D - 1);
          sb.push_back(e);
        end
        wcnt = 0;
        blk_done_cyc = cyc;
      end
    end
    if (got) begin
      n_outs++;
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("out_last", 32'(bus.out_last), 32'(e.last));
      end
    end
    prev_v = bus.out_valid;
    prev_r = bus.out_ready;
    prev_l = bus.out_last;
    prev_d = bus.out_data;
  endtask

  task automatic drain(input int rpct);
    logic a, g, l;
    int guard = 0;
    while (sb.size() > 0 && guard < 5000) begin
      cycle(1'b0, '0, 1'($urandom_range(1, 100) <= rpct), a, g, l);
      guard++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    cycle(1'b0, '0, 1'b1, a, g, l);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_blocks(input int nblk, input int vpct, input int rpct);
    logic a, g, l;
    logic [W-1:0] v = W'($urandom);
    int acc_n = 0;
    int guard = 0;
    while (acc_n < nblk * D && guard < 20000) begin
      cycle(1'($urandom_range(1, 100) <= vpct), v, 1'($urandom_range(1, 100) <= rpct), a, g, l);
      if (a) begin
        acc_n++;
        v = W'($urandom);
      end
      guard++;
    end
    chk("feed_done", 32'(acc_n), 32'(nblk * D));
    drain(rpct);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    sb.delete();
    wcnt   = 0;
    prev_v = 1'b0;
    prev_r = 1'b0;
  endtask

  scen_t tbl [4];

  initial begin
    logic a, g, l;
    logic [W-1:0] v;
    int acc_n, guard, first_out, last_out, n0, prev_ir;
    logic seen_last;

    tbl[0] = '{nblk: 2,  vpct: 100, rpct: 100, exp_outs: 128};
    tbl[1] = '{nblk: 3,  vpct: 100, rpct: 50,  exp_outs: 192};
    tbl[2] = '{nblk: 10, vpct: 50,  rpct: 50,  exp_outs: 640};
    tbl[3] = '{nblk: 4,  vpct: 80,  rpct: 30,  exp_outs: 256};

    n_checks = 0; n_pass = 0; n_outs = 0; wcnt = 0; cyc = 0;
    prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b0, a, g, l);
      chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
      chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t1_out_last", 32'(bus.out_last), 32'd0);
    end

    // One block of 0..63 with consumer always ready: latency and no gaps.
    v = '0; acc_n = 0; guard = 0; first_out = -1; last_out = -1;
    while (acc_n < D && guard < 200) begin
      cycle(1'b1, v, 1'b1, a, g, l);
      if (a) begin acc_n++; v++; end
      guard++;
    end
    chk("t2_fed", 32'(acc_n), 32'(D));
    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      cycle(1'b0, '0, 1'b1, a, g, l);
      if (g && first_out < 0) first_out = cyc;
      if (g) last_out = cyc;
      guard++;
    end
    chk("t2_latency", 32'(first_out - blk_done_cyc), 32'd2);
    chk("t2_no_gaps", 32'(last_out - first_out), 32'(D - 1));
    cycle(1'b0, '0, 1'b1, a, g, l);
    chk("t2_idle", 32'(bus.out_valid), 32'd0);

    // Three blocks with consumer stalled: both banks fill, then drain.
    v = 8'h40; acc_n = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, v, 1'b0, a, g, l);
      if (a) begin acc_n++; v++; end
    end
    chk("t4_fill_two", 32'(acc_n), 32'(2 * D));
    chk("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("t4_out_held", 32'(bus.out_valid), 32'd1);
    prev_ir = 0; seen_last = 1'b0; guard = 0;
    while ((acc_n < 3 * D || sb.size() > 0) && guard < 1000) begin
      cycle(acc_n < 3 * D, v, 1'b1, a, g, l);
      if (a) begin acc_n++; v++; end
      if (g && l && !seen_last) begin
        seen_last = 1'b1;
        chk("t4_ready_after_free", 32'(bus.in_ready), 32'd1);
        chk("t4_ready_before_free", 32'(prev_ir), 32'd0);
      end
      prev_ir = int'(bus.in_ready);
      guard++;
    end
    chk("t4_saw_last", 32'(seen_last), 32'd1);
    chk("t4_all_fed", 32'(acc_n), 32'(3 * D));
    drain(100);

    // Scenario table: random valid/ready densities over many blocks.
    for (int i = 0; i < 4; i++) begin
      n0 = n_outs;
      run_blocks(tbl[i].nblk, tbl[i].vpct, tbl[i].rpct);
      chk("scen_outs", 32'(n_outs - n0), 32'(tbl[i].exp_outs));
    end

    // Reset in the middle of a partial write.
    acc_n = 0; guard = 0; v = 8'hA0;
    while (acc_n < 30 && guard < 200) begin
      cycle(1'b1, v, 1'b1, a, g, l);
      if (a) begin acc_n++; v++; end
      guard++;
    end
    do_reset();

    // Reset in the middle of a drain.
    acc_n = 0; guard = 0; n0 = n_outs;
    while ((acc_n < D || n_outs - n0 < 20) && guard < 400) begin
      cycle(acc_n < D, v, 1'b1, a, g, l);
      if (a) begin acc_n++; v++; end
      guard++;
    end
    chk("t6_partial_outs", 32'(n_outs - n0), 32'd20);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, a, g, l);
      chk("t6_no_stale", 32'(bus.out_valid), 32'd0);
    end
    n0 = n_outs;
    run_blocks(1, 100, 100);
    chk("t6_fresh_outs", 32'(n_outs - n0), 32'(D));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
